// File: rtl/physics_pkg.sv
// Shared types and helpers for the obstacle sweep sequencer and the collision engine.
// Holds the sweep state encoding, default widths, vertex-bus unpackers and a saturating adder.
package physics_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_WAIT,
        S_NEXT,
        S_DONE
    } sweep_state_t;

    localparam int POSITION_SIZE     = 8;
    localparam int VELOCITY_SIZE     = 8;
    localparam int ACCELERATION_SIZE = 8;
    localparam int NUM_VERTICES      = 5;
    localparam int MAX_OBSTACLES     = 16;
    localparam int OBS_AW            = $clog2(MAX_OBSTACLES);
    localparam int NV_W              = $clog2(NUM_VERTICES) + 1;
    localparam int VERT_W            = 2 * NUM_VERTICES * POSITION_SIZE;

    // Vertex bus layout is {y[N-1..0], x[N-1..0]}, x[0] in the least significant slot.
    function automatic logic [POSITION_SIZE-1:0] vert_x(input logic [VERT_W-1:0] verts,
                                                         input int i);
        return verts[i*POSITION_SIZE +: POSITION_SIZE];
    endfunction

    function automatic logic [POSITION_SIZE-1:0] vert_y(input logic [VERT_W-1:0] verts,
                                                         input int i);
        return verts[(NUM_VERTICES + i)*POSITION_SIZE +: POSITION_SIZE];
    endfunction

    // Adds two sign-extended operands and clamps the result to a signed w-bit range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        longint s;
        longint hi;
        longint lo;
        s  = longint'(a) + longint'(b);
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return 32'(s);
    endfunction

endpackage

// File: rtl/obstacle_sweep.sv
// Walks the obstacle table once per physics step, launching the collision engine per obstacle
// and chaining its post-collision state into the next launch; reports one final result.
module obstacle_sweep #(
    parameter int POSITION_SIZE     = 8,
    parameter int VELOCITY_SIZE     = 8,
    parameter int ACCELERATION_SIZE = 8,
    parameter int NUM_VERTICES      = 5,
    parameter int MAX_OBSTACLES     = 16
) (
    input  logic                                       clk_in,
    input  logic                                       rst_in,
    input  logic                                       begin_in,
    input  logic [$clog2(MAX_OBSTACLES):0]             num_obstacles_in,
    input  logic [POSITION_SIZE-1:0]                   pos_x_in,
    input  logic [POSITION_SIZE-1:0]                   pos_y_in,
    input  logic [VELOCITY_SIZE-1:0]                   vel_x_in,
    input  logic [VELOCITY_SIZE-1:0]                   vel_y_in,
    input  logic [POSITION_SIZE-1:0]                   dx_in,
    input  logic [POSITION_SIZE-1:0]                   dy_in,
    output logic [$clog2(MAX_OBSTACLES)-1:0]           obs_addr_out,
    input  logic [2*NUM_VERTICES*POSITION_SIZE-1:0]    obs_vert_in,
    input  logic [$clog2(NUM_VERTICES):0]              obs_nv_in,
    output logic                                       coll_begin_out,
    output logic [2*NUM_VERTICES*POSITION_SIZE-1:0]    coll_obstacle_out,
    output logic [$clog2(NUM_VERTICES):0]              coll_nv_out,
    output logic [POSITION_SIZE-1:0]                   coll_pos_x_out,
    output logic [POSITION_SIZE-1:0]                   coll_pos_y_out,
    output logic [VELOCITY_SIZE-1:0]                   coll_vel_x_out,
    output logic [VELOCITY_SIZE-1:0]                   coll_vel_y_out,
    output logic [POSITION_SIZE-1:0]                   coll_dx_out,
    output logic [POSITION_SIZE-1:0]                   coll_dy_out,
    input  logic                                       coll_result_in,
    input  logic                                       coll_was_collision_in,
    input  logic [POSITION_SIZE-1:0]                   coll_x_new_in,
    input  logic [POSITION_SIZE-1:0]                   coll_y_new_in,
    input  logic [VELOCITY_SIZE-1:0]                   coll_vx_new_in,
    input  logic [VELOCITY_SIZE-1:0]                   coll_vy_new_in,
    input  logic [POSITION_SIZE-1:0]                   coll_x_int_in,
    input  logic [POSITION_SIZE-1:0]                   coll_y_int_in,
    input  logic [ACCELERATION_SIZE-1:0]               coll_ax_in,
    input  logic [ACCELERATION_SIZE-1:0]               coll_ay_in,
    output logic                                       busy_out,
    output logic                                       done_out,
    output logic [POSITION_SIZE-1:0]                   x_out,
    output logic [POSITION_SIZE-1:0]                   y_out,
    output logic [VELOCITY_SIZE-1:0]                   vel_x_out,
    output logic [VELOCITY_SIZE-1:0]                   vel_y_out,
    output logic [ACCELERATION_SIZE-1:0]               acc_x_out,
    output logic [ACCELERATION_SIZE-1:0]               acc_y_out,
    output logic                                       any_collision_out
);
    import physics_pkg::*;

    localparam int OBS_W  = $clog2(MAX_OBSTACLES);
    localparam int NVW    = $clog2(NUM_VERTICES) + 1;
    localparam int VERTW  = 2 * NUM_VERTICES * POSITION_SIZE;

    sweep_state_t state_reg;
    sweep_state_t state_next;

    logic [OBS_W-1:0]             idx_reg;
    logic [OBS_W:0]               num_reg;
    logic [POSITION_SIZE-1:0]     cp_x_reg, cp_y_reg;
    logic [VELOCITY_SIZE-1:0]     cv_x_reg, cv_y_reg;
    logic [POSITION_SIZE-1:0]     cd_x_reg, cd_y_reg;
    logic [ACCELERATION_SIZE-1:0] acc_x_reg, acc_y_reg;
    logic [POSITION_SIZE-1:0]     fin_x_reg, fin_y_reg;
    logic                         hit_reg;
    logic [VERTW-1:0]             obs_reg;
    logic [NVW-1:0]               nv_reg;

    logic [POSITION_SIZE-1:0]     x_out_reg, y_out_reg;
    logic [VELOCITY_SIZE-1:0]     vel_x_out_reg, vel_y_out_reg;
    logic [ACCELERATION_SIZE-1:0] acc_x_out_reg, acc_y_out_reg;
    logic                         any_reg;
    logic                         done_reg;

    logic                         nv_ok;
    logic                         last_obs;
    logic [POSITION_SIZE-1:0]     d_x_sat, d_y_sat;
    logic [ACCELERATION_SIZE-1:0] acc_x_sum, acc_y_sum;

    // Polygons need at least three vertices and must fit the vertex bus.
    assign nv_ok    = (obs_nv_in >= NVW'(3)) && (obs_nv_in <= NVW'(NUM_VERTICES));
    assign last_obs = ({1'b0, idx_reg} == (num_reg - 1'b1));

    // Residual displacement after a hit is new-int, widened so it cannot wrap before clamping.
    always_comb begin
        d_x_sat   = POSITION_SIZE'(sat_add(32'(signed'(coll_x_new_in)),
                                           -32'(signed'(coll_x_int_in)), POSITION_SIZE));
        d_y_sat   = POSITION_SIZE'(sat_add(32'(signed'(coll_y_new_in)),
                                           -32'(signed'(coll_y_int_in)), POSITION_SIZE));
        acc_x_sum = ACCELERATION_SIZE'(sat_add(32'(signed'(acc_x_reg)),
                                               32'(signed'(coll_ax_in)), ACCELERATION_SIZE));
        acc_y_sum = ACCELERATION_SIZE'(sat_add(32'(signed'(acc_y_reg)),
                                               32'(signed'(coll_ay_in)), ACCELERATION_SIZE));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        coll_begin_out = 1'b0;
        busy_out       = (state_reg != S_IDLE);
        case (state_reg)
            S_IDLE: begin
                if (begin_in) begin
                    state_next = (num_obstacles_in == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_next = S_LOAD;
            S_LOAD:  state_next = nv_ok ? S_START : S_NEXT;
            S_START: begin
                coll_begin_out = 1'b1;
                state_next     = S_WAIT;
            end
            S_WAIT: begin
                if (coll_result_in) begin
                    state_next = S_NEXT;
                end
            end
            S_NEXT:  state_next = last_obs ? S_DONE : S_FETCH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_reg       <= '0;
            num_reg       <= '0;
            cp_x_reg      <= '0;
            cp_y_reg      <= '0;
            cv_x_reg      <= '0;
            cv_y_reg      <= '0;
            cd_x_reg      <= '0;
            cd_y_reg      <= '0;
            acc_x_reg     <= '0;
            acc_y_reg     <= '0;
            fin_x_reg     <= '0;
            fin_y_reg     <= '0;
            hit_reg       <= 1'b0;
            obs_reg       <= '0;
            nv_reg        <= '0;
            x_out_reg     <= '0;
            y_out_reg     <= '0;
            vel_x_out_reg <= '0;
            vel_y_out_reg <= '0;
            acc_x_out_reg <= '0;
            acc_y_out_reg <= '0;
            any_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= (state_reg == S_DONE);
            case (state_reg)
                S_IDLE: begin
                    if (begin_in) begin
                        idx_reg   <= '0;
                        num_reg   <= num_obstacles_in;
                        cp_x_reg  <= pos_x_in;
                        cp_y_reg  <= pos_y_in;
                        cv_x_reg  <= vel_x_in;
                        cv_y_reg  <= vel_y_in;
                        cd_x_reg  <= dx_in;
                        cd_y_reg  <= dy_in;
                        acc_x_reg <= '0;
                        acc_y_reg <= '0;
                        hit_reg   <= 1'b0;
                        // Unobstructed end point; replaced by the engine's position on a hit.
                        fin_x_reg <= pos_x_in + dx_in;
                        fin_y_reg <= pos_y_in + dy_in;
                    end
                end
                S_LOAD: begin
                    if (nv_ok) begin
                        obs_reg <= obs_vert_in;
                        nv_reg  <= obs_nv_in;
                    end
                end
                S_WAIT: begin
                    if (coll_result_in && coll_was_collision_in) begin
                        cp_x_reg  <= coll_x_int_in;
                        cp_y_reg  <= coll_y_int_in;
                        cv_x_reg  <= coll_vx_new_in;
                        cv_y_reg  <= coll_vy_new_in;
                        cd_x_reg  <= d_x_sat;
                        cd_y_reg  <= d_y_sat;
                        acc_x_reg <= acc_x_sum;
                        acc_y_reg <= acc_y_sum;
                        fin_x_reg <= coll_x_new_in;
                        fin_y_reg <= coll_y_new_in;
                        hit_reg   <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (!last_obs) begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    x_out_reg     <= fin_x_reg;
                    y_out_reg     <= fin_y_reg;
                    vel_x_out_reg <= cv_x_reg;
                    vel_y_out_reg <= cv_y_reg;
                    acc_x_out_reg <= acc_x_reg;
                    acc_y_out_reg <= acc_y_reg;
                    any_reg       <= hit_reg;
                end
                default: ;
            endcase
        end
    end

    assign obs_addr_out      = idx_reg;
    assign coll_obstacle_out = obs_reg;
    assign coll_nv_out       = nv_reg;
    assign coll_pos_x_out    = cp_x_reg;
    assign coll_pos_y_out    = cp_y_reg;
    assign coll_vel_x_out    = cv_x_reg;
    assign coll_vel_y_out    = cv_y_reg;
    assign coll_dx_out       = cd_x_reg;
    assign coll_dy_out       = cd_y_reg;
    assign done_out          = done_reg;
    assign x_out             = x_out_reg;
    assign y_out             = y_out_reg;
    assign vel_x_out         = vel_x_out_reg;
    assign vel_y_out         = vel_y_out_reg;
    assign acc_x_out         = acc_x_out_reg;
    assign acc_y_out         = acc_y_out_reg;
    assign any_collision_out = any_reg;

endmodule

// File: tb/tb_obstacle_sweep.sv
// Scoreboard bench for obstacle_sweep: a table model, a behavioural engine model and a monitor
// that checks every engine launch and every done pulse against hand-computed expectations.
module tb_obstacle_sweep;

    localparam int P   = 8;
    localparam int NV  = 5;
    localparam int VW  = 2 * NV * P;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            begin_in;
    logic [4:0]      num_obstacles_in;
    logic [P-1:0]    pos_x_in, pos_y_in, vel_x_in, vel_y_in, dx_in, dy_in;
    logic [3:0]      obs_addr_out;
    logic [VW-1:0]   obs_vert_in;
    logic [3:0]      obs_nv_in;
    logic            coll_begin_out;
    logic [VW-1:0]   coll_obstacle_out;
    logic [3:0]      coll_nv_out;
    logic [P-1:0]    coll_pos_x_out, coll_pos_y_out, coll_vel_x_out, coll_vel_y_out;
    logic [P-1:0]    coll_dx_out, coll_dy_out;
    logic            coll_result_in, coll_was_collision_in;
    logic [P-1:0]    coll_x_new_in, coll_y_new_in, coll_vx_new_in, coll_vy_new_in;
    logic [P-1:0]    coll_x_int_in, coll_y_int_in, coll_ax_in, coll_ay_in;
    logic            busy_out, done_out;
    logic [P-1:0]    x_out, y_out, vel_x_out, vel_y_out, acc_x_out, acc_y_out;
    logic            any_collision_out;

    obstacle_sweep dut (
        .clk_in(clk_in), .rst_in(rst_in), .begin_in(begin_in),
        .num_obstacles_in(num_obstacles_in),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
        .dx_in(dx_in), .dy_in(dy_in),
        .obs_addr_out(obs_addr_out), .obs_vert_in(obs_vert_in), .obs_nv_in(obs_nv_in),
        .coll_begin_out(coll_begin_out), .coll_obstacle_out(coll_obstacle_out),
        .coll_nv_out(coll_nv_out),
        .coll_pos_x_out(coll_pos_x_out), .coll_pos_y_out(coll_pos_y_out),
        .coll_vel_x_out(coll_vel_x_out), .coll_vel_y_out(coll_vel_y_out),
        .coll_dx_out(coll_dx_out), .coll_dy_out(coll_dy_out),
        .coll_result_in(coll_result_in), .coll_was_collision_in(coll_was_collision_in),
        .coll_x_new_in(coll_x_new_in), .coll_y_new_in(coll_y_new_in),
        .coll_vx_new_in(coll_vx_new_in), .coll_vy_new_in(coll_vy_new_in),
        .coll_x_int_in(coll_x_int_in), .coll_y_int_in(coll_y_int_in),
        .coll_ax_in(coll_ax_in), .coll_ay_in(coll_ay_in),
        .busy_out(busy_out), .done_out(done_out),
        .x_out(x_out), .y_out(y_out), .vel_x_out(vel_x_out), .vel_y_out(vel_y_out),
        .acc_x_out(acc_x_out), .acc_y_out(acc_y_out),
        .any_collision_out(any_collision_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int idx; int px; int py; int vx; int vy; int dx; int dy; int nv;
    } launch_t;

    typedef struct {
        int x; int y; int vx; int vy; int ax; int ay; int any; int lat;
    } final_t;

    launch_t lq[$];
    final_t  fq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int begin_cyc = 0;
    int done_cnt = 0;
    int launch_cnt = 0;

    logic [VW-1:0] vmem[16];
    logic [3:0]    nvmem[16];

    bit eh[16];
    int eix[16], eiy[16], enx[16], eny[16], evx[16], evy[16], eax[16], eay[16];
    int eng_cnt = 0;
    int eng_idx = 0;

    function automatic logic [VW-1:0] mk_vert(input int idx);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < NV; i++) begin
            v[i*P +: P]      = P'(idx * 16 + i);
            v[(NV+i)*P +: P] = P'(idx * 16 + 8 + i);
        end
        return v;
    endfunction

    function automatic int s8(input logic [P-1:0] v);
        return int'(signed'(v));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        obs_vert_in <= vmem[obs_addr_out];
        obs_nv_in   <= nvmem[obs_addr_out];
    end

    // Engine model: answers three cycles after each launch, using the per-obstacle table.
    initial begin
        coll_result_in = 1'b0; coll_was_collision_in = 1'b0;
        coll_x_new_in = '0; coll_y_new_in = '0; coll_vx_new_in = '0; coll_vy_new_in = '0;
        coll_x_int_in = '0; coll_y_int_in = '0; coll_ax_in = '0; coll_ay_in = '0;
        forever begin
            @(negedge clk_in);
            coll_result_in = 1'b0;
            coll_was_collision_in = 1'b0;
            if (eng_cnt == 1) begin
                coll_result_in        = 1'b1;
                coll_was_collision_in = eh[eng_idx];
                coll_x_int_in  = P'(eix[eng_idx]); coll_y_int_in  = P'(eiy[eng_idx]);
                coll_x_new_in  = P'(enx[eng_idx]); coll_y_new_in  = P'(eny[eng_idx]);
                coll_vx_new_in = P'(evx[eng_idx]); coll_vy_new_in = P'(evy[eng_idx]);
                coll_ax_in     = P'(eax[eng_idx]); coll_ay_in     = P'(eay[eng_idx]);
            end
            if (eng_cnt > 0) eng_cnt--;
            if (coll_begin_out) begin
                eng_idx = int'(coll_obstacle_out[3:0] >> 0) & 15;
                eng_idx = int'(coll_obstacle_out[7:4]);
                eng_cnt = 3;
            end
        end
    end

    // Monitor: one line per launch and per done, compared against the scoreboard queues.
    initial begin
        launch_t l;
        final_t  f;
        forever begin
            @(negedge clk_in);
            if (coll_begin_out) begin
                launch_cnt++;
                if (lq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL launch_unexpected: got launch at addr %0d expected none", obs_addr_out);
                end else begin
                    l = lq.pop_front();
                    $display("launch idx=%0d pos=(%0d,%0d) v=(%0d,%0d) d=(%0d,%0d)", l.idx,
                             s8(coll_pos_x_out), s8(coll_pos_y_out), s8(coll_vel_x_out),
                             s8(coll_vel_y_out), s8(coll_dx_out), s8(coll_dy_out));
                    total++;
                    if (coll_obstacle_out != mk_vert(l.idx)) begin
                        bad++;
                        $display("FAIL launch_obstacle: got %h expected %h", coll_obstacle_out, mk_vert(l.idx));
                    end
                    chk("launch_nv", int'(coll_nv_out), l.nv);
                    chk("launch_pos_x", s8(coll_pos_x_out), l.px);
                    chk("launch_pos_y", s8(coll_pos_y_out), l.py);
                    chk("launch_vel_x", s8(coll_vel_x_out), l.vx);
                    chk("launch_vel_y", s8(coll_vel_y_out), l.vy);
                    chk("launch_dx", s8(coll_dx_out), l.dx);
                    chk("launch_dy", s8(coll_dy_out), l.dy);
                end
            end
            if (done_out) begin
                done_cnt++;
                if (fq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got done pulse expected none");
                end else begin
                    f = fq.pop_front();
                    $display("done pos=(%0d,%0d) v=(%0d,%0d) a=(%0d,%0d) any=%0d",
                             s8(x_out), s8(y_out), s8(vel_x_out), s8(vel_y_out),
                             s8(acc_x_out), s8(acc_y_out), any_collision_out);
                    chk("final_x", s8(x_out), f.x);
                    chk("final_y", s8(y_out), f.y);
                    chk("final_vx", s8(vel_x_out), f.vx);
                    chk("final_vy", s8(vel_y_out), f.vy);
                    chk("final_ax", s8(acc_x_out), f.ax);
                    chk("final_ay", s8(acc_y_out), f.ay);
                    chk("final_any", int'(any_collision_out), f.any);
                    if (f.lat != 0) chk("done_latency", cyc - begin_cyc, f.lat);
                end
            end
        end
    end

    task automatic push_launch(input int idx, input int px, input int py, input int vx,
                               input int vy, input int dx, input int dy);
        launch_t l;
        l.idx = idx; l.px = px; l.py = py; l.vx = vx; l.vy = vy; l.dx = dx; l.dy = dy; l.nv = 4;
        lq.push_back(l);
    endtask

    task automatic push_final(input int x, input int y, input int vx, input int vy,
                              input int ax, input int ay, input int any, input int lat);
        final_t f;
        f.x = x; f.y = y; f.vx = vx; f.vy = vy; f.ax = ax; f.ay = ay; f.any = any; f.lat = lat;
        fq.push_back(f);
    endtask

    task automatic set_engine(input int idx, input int ax, input int ay);
        eh[idx] = 1'b1;
        eix[idx] = 12; eiy[idx] = 9; enx[idx] = 11; eny[idx] = 11;
        evx[idx] = -1; evy[idx] = 2; eax[idx] = ax; eay[idx] = ay;
    endtask

    task automatic clear_engine();
        for (int i = 0; i < 16; i++) eh[i] = 1'b0;
    endtask

    task automatic pulse_begin(input int n);
        @(negedge clk_in);
        num_obstacles_in = 5'(n);
        begin_in  = 1'b1;
        begin_cyc = cyc;
        @(negedge clk_in);
        begin_in = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            if (done_cnt >= target) break;
            @(negedge clk_in);
        end
        if (done_cnt < target) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d done pulses expected %0d", name, done_cnt, target);
        end
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        int i;
        int target;
        for (int k = 0; k < 16; k++) begin
            vmem[k] = mk_vert(k);
            nvmem[k] = 4'd4;
            eh[k] = 1'b0;
        end
        rst_in = 1'b1; begin_in = 1'b0; num_obstacles_in = '0;
        pos_x_in = P'(10); pos_y_in = P'(10); vel_x_in = P'(1); vel_y_in = P'(1);
        dx_in = P'(3); dy_in = P'(-2);
        repeat (3) @(negedge clk_in);
        chk("reset_x", s8(x_out), 0);
        chk("reset_acc_x", s8(acc_x_out), 0);
        chk("reset_done", int'(done_out), 0);
        chk("reset_busy", int'(busy_out), 0);
        chk("reset_coll_begin", int'(coll_begin_out), 0);
        chk("reset_addr", int'(obs_addr_out), 0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // No obstacles: straight move, done two cycles after begin.
        push_final(13, 8, 1, 1, 0, 0, 0, 2);
        target = done_cnt + 1;
        pulse_begin(0);
        wait_done(target, "empty_sweep");

        // Three obstacles, engine never hits.
        clear_engine();
        for (int k = 0; k < 3; k++) push_launch(k, 10, 10, 1, 1, 3, -2);
        push_final(13, 8, 1, 1, 0, 0, 0, 0);
        target = done_cnt + 1;
        pulse_begin(3);
        wait_done(target, "no_hit");

        // Obstacle 1 hits; obstacle 2 sees the chained state.
        clear_engine();
        set_engine(1, 0, 5);
        push_launch(0, 10, 10, 1, 1, 3, -2);
        push_launch(1, 10, 10, 1, 1, 3, -2);
        push_launch(2, 12, 9, -1, 2, -1, 2);
        push_final(11, 11, -1, 2, 0, 5, 1, 0);
        target = done_cnt + 1;
        pulse_begin(3);
        wait_done(target, "one_hit");

        // Two hits with large accelerations saturate the sums.
        clear_engine();
        set_engine(0, 100, -100);
        set_engine(1, 100, -100);
        push_launch(0, 10, 10, 1, 1, 3, -2);
        push_launch(1, 12, 9, -1, 2, -1, 2);
        push_final(11, 11, -1, 2, 127, -128, 1, 0);
        target = done_cnt + 1;
        pulse_begin(2);
        wait_done(target, "saturate");

        // Degenerate obstacle 0 is skipped without a launch.
        clear_engine();
        nvmem[0] = 4'd2;
        push_launch(1, 10, 10, 1, 1, 3, -2);
        push_final(13, 8, 1, 1, 0, 0, 0, 0);
        target = done_cnt + 1;
        pulse_begin(2);
        wait_done(target, "skip_nv2");
        nvmem[0] = 4'd4;

        // Reset while the engine is busy: late result must be ignored, no done pulse.
        clear_engine();
        set_engine(0, 7, 7);
        push_launch(0, 10, 10, 1, 1, 3, -2);
        target = launch_cnt + 1;
        pulse_begin(3);
        for (i = 0; i < 100; i++) begin
            if (launch_cnt >= target) break;
            @(negedge clk_in);
        end
        if (launch_cnt < target) begin
            total++; bad++;
            $display("FAIL reset_launch_timeout: got %0d launches expected %0d", launch_cnt, target);
        end
        target = done_cnt;
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (20) @(negedge clk_in);
        chk("abort_done_count", done_cnt, target);
        chk("abort_x", s8(x_out), 0);
        chk("abort_acc_x", s8(acc_x_out), 0);
        chk("abort_any", int'(any_collision_out), 0);
        chk("abort_busy", int'(busy_out), 0);

        // Normal sweep after the abort, with a stray begin while busy.
        clear_engine();
        for (int k = 0; k < 3; k++) push_launch(k, 10, 10, 1, 1, 3, -2);
        push_final(13, 8, 1, 1, 0, 0, 0, 0);
        target = done_cnt + 1;
        pulse_begin(3);
        repeat (5) @(negedge clk_in);
        begin_in = 1'b1;
        @(negedge clk_in);
        begin_in = 1'b0;
        wait_done(target, "busy_begin");
        repeat (20) @(negedge clk_in);

        chk("launch_queue_left", lq.size(), 0);
        chk("final_queue_left", fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
